// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame scheduler.
package ws2812_pkg;

  localparam int MATRIX_W = 16;
  localparam int NUM_LEDS = MATRIX_W * MATRIX_W;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } color_t;

  typedef enum logic {
    SRC_GAME = 1'b0,
    SRC_DBG  = 1'b1
  } src_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    LOAD    = 3'd2,
    KICK    = 3'd3,
    WAIT_ST = 3'd4,
    WAIT_DN = 3'd5
  } state_t;

  // Serpentine wiring: even rows run right-to-left along the chain, odd rows left-to-right.
  function automatic int led_index(input int row, input int col);
    if ((row % 2) == 0) begin
      return row * MATRIX_W + (MATRIX_W - 1 - col);
    end
    return row * MATRIX_W + col;
  endfunction

endpackage

// File: rtl/ws2812_pixel_map.sv
// Combinational bitmap-to-chain mapping: one color for every set bit, black otherwise.
module ws2812_pixel_map
  import ws2812_pkg::*;
(
  input  logic [NUM_LEDS-1:0]   bits,
  input  color_t                color,
  output color_t [NUM_LEDS-1:0] pixels
);

  for (genvar r = 0; r < MATRIX_W; r++) begin : g_row
    for (genvar c = 0; c < MATRIX_W; c++) begin : g_col
      assign pixels[led_index(r, c)] = bits[r * MATRIX_W + c] ? color : '0;
    end
  end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Frame-rate refresh sequencer for the WS2812 driver with two-source round-robin arbitration.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | waiting for a pending frame tick and at least one request
//  ARB     | pick the winning source, latch it
//  LOAD    | capture mapped pixels, pulse the winner's grant
//  KICK    | one-cycle drv_update strobe
//  WAIT_ST | waiting for driver busy to rise, bounded by BUSY_TIMEOUT
//  WAIT_DN | waiting for driver busy to fall, then count the frame
module ws2812_frame_scheduler
  import ws2812_pkg::*;
#(
  parameter int CLK_FREQ     = 20_000_000,
  parameter int FRAME_PERIOD = CLK_FREQ / 60,
  parameter int BUSY_TIMEOUT = 64
)(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_game,
  input  logic [NUM_LEDS-1:0]   game_bits,
  input  color_t                game_color,
  output logic                  gnt_game,
  input  logic                  req_dbg,
  input  logic [NUM_LEDS-1:0]   dbg_bits,
  input  color_t                dbg_color,
  input  logic                  dbg_force,
  output logic                  gnt_dbg,
  input  logic                  drv_busy,
  output logic                  drv_update,
  output color_t [NUM_LEDS-1:0] drv_data,
  output logic [15:0]           frame_count,
  output logic                  err_timeout
);

  localparam int TIMER_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int WAIT_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME_PERIOD - 1);
  // The KICK cycle counts as the first timeout cycle, so WAIT_ST gives up one short of the limit.
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(BUSY_TIMEOUT - 1);

  state_t                state_q, state_d;
  src_t                  winner_q, winner_d, last_winner_q, arb_pick;
  logic                  tick_pend_q;
  logic [TIMER_W-1:0]    timer_q;
  logic [WAIT_W-1:0]     wait_cnt_q;
  logic [15:0]           frame_count_q;
  logic                  err_q;
  logic                  tick_wrap;
  logic                  any_req;
  logic                  busy_timeout;
  logic [NUM_LEDS-1:0]   map_bits;
  color_t                map_color;
  color_t [NUM_LEDS-1:0] mapped;
  color_t [NUM_LEDS-1:0] drv_data_q;

  assign tick_wrap    = (timer_q == TIMER_LAST);
  assign any_req      = req_game | req_dbg;
  assign busy_timeout = (state_q == WAIT_ST) && !drv_busy && (wait_cnt_q == WAIT_LAST);

  // Forced debug wins outright; otherwise a lone requester wins, and a tie goes to the source not served last.
  assign arb_pick = (req_dbg && (dbg_force || !req_game || last_winner_q == SRC_GAME)) ? SRC_DBG : SRC_GAME;

  assign map_bits  = (winner_q == SRC_DBG) ? dbg_bits  : game_bits;
  assign map_color = (winner_q == SRC_DBG) ? dbg_color : game_color;

  ws2812_pixel_map u_pixel_map (
    .bits   (map_bits),
    .color  (map_color),
    .pixels (mapped)
  );

  // Free-running frame timer, wraps every FRAME_PERIOD cycles regardless of FSM state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (tick_wrap) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TIMER_W'(1);
    end
  end

  // Pending tick: set on every wrap (repeats merge), consumed when ARB is left.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_pend_q <= 1'b0;
    end else if (tick_wrap) begin
      tick_pend_q <= 1'b1;
    end else if (state_q == ARB) begin
      tick_pend_q <= 1'b0;
    end
  end

  // Busy-rise wait counter, running from KICK through WAIT_ST.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == KICK || state_q == WAIT_ST) begin
      wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // FSM state and latched winner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      winner_q <= SRC_GAME;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    gnt_game   = 1'b0;
    gnt_dbg    = 1'b0;
    drv_update = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_pend_q && any_req) state_d = ARB;
      end
      ARB: begin
        // A request withdrawn by now gets nothing; the tick is still consumed.
        if (any_req) begin
          winner_d = arb_pick;
          state_d  = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        gnt_game = (winner_q == SRC_GAME);
        gnt_dbg  = (winner_q == SRC_DBG);
        state_d  = KICK;
      end
      KICK: begin
        drv_update = 1'b1;
        state_d    = WAIT_ST;
      end
      WAIT_ST: begin
        if (drv_busy) begin
          state_d = WAIT_DN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = IDLE;
        end
      end
      WAIT_DN: begin
        if (!drv_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel bank, round-robin history, frame counter and sticky timeout flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drv_data_q    <= '0;
      last_winner_q <= SRC_DBG;
      frame_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      if (state_q == LOAD) begin
        drv_data_q    <= mapped;
        last_winner_q <= winner_q;
      end
      if (state_q == WAIT_DN && !drv_busy) frame_count_q <= frame_count_q + 16'd1;
      if (busy_timeout) err_q <= 1'b1;
    end
  end

  assign drv_data    = drv_data_q;
  assign frame_count = frame_count_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Directed bench for ws2812_frame_scheduler with a simple behavioural driver model.
`timescale 1ns/1ps
module tb_ws2812_frame_scheduler;
  import ws2812_pkg::*;

  localparam int FP = 100;
  localparam int BT = 64;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_game, req_dbg, dbg_force, drv_busy;
  logic [255:0]  game_bits, dbg_bits;
  logic [23:0]   game_color, dbg_color;
  logic          gnt_game, gnt_dbg, drv_update, err_timeout;
  color_t [255:0] drv_data;
  logic [15:0]   frame_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int n_upd, n_gnt;
  bit drv_en;
  int busy_dly, busy_len, dcnt;

  // expected dbg grant per frame: row 0 round-robin, row 1 with dbg_force
  bit exp_dbg [2][4] = '{'{1'b0, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1, 1'b1}};

  ws2812_frame_scheduler #(
    .CLK_FREQ     (20_000_000),
    .FRAME_PERIOD (FP),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_game    (req_game),
    .game_bits   (game_bits),
    .game_color  (game_color),
    .gnt_game    (gnt_game),
    .req_dbg     (req_dbg),
    .dbg_bits    (dbg_bits),
    .dbg_color   (dbg_color),
    .dbg_force   (dbg_force),
    .gnt_dbg     (gnt_dbg),
    .drv_busy    (drv_busy),
    .drv_update  (drv_update),
    .drv_data    (drv_data),
    .frame_count (frame_count),
    .err_timeout (err_timeout)
  );

  always #5 clock = ~clock;

  // cycle index since reset release, plus update/grant tallies
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc   <= 0;
      n_upd <= 0;
      n_gnt <= 0;
    end else begin
      cyc <= cyc + 1;
      if (drv_update) n_upd <= n_upd + 1;
      if (gnt_game || gnt_dbg) n_gnt <= n_gnt + 1;
    end
  end

  // driver model: busy rises busy_dly cycles after the update, stays high busy_len cycles
  always @(negedge clock) begin
    if (!reset_n) begin
      dcnt     = -1;
      drv_busy = 1'b0;
    end else begin
      if (drv_update && drv_en) dcnt = 0;
      else if (dcnt >= 0) dcnt = dcnt + 1;
      if (dcnt >= busy_dly + busy_len) dcnt = -1;
      drv_busy = (dcnt >= busy_dly);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lit_count();
    int n = 0;
    for (int i = 0; i < 256; i++) if (drv_data[i] != '0) n++;
    return n;
  endfunction

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req_game   = 1'b0;
    req_dbg    = 1'b0;
    dbg_force  = 1'b0;
    game_bits  = '0;
    dbg_bits   = '0;
    game_color = '0;
    dbg_color  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    drv_en   = 1'b1;
    busy_dly = 2;
    busy_len = 20;

    // reset values and single game frame
    do_reset();
    check_eq("rst_gnt_game", 32'(gnt_game), 32'd0);
    check_eq("rst_gnt_dbg", 32'(gnt_dbg), 32'd0);
    check_eq("rst_update", 32'(drv_update), 32'd0);
    check_eq("rst_frame_count", 32'(frame_count), 32'd0);
    check_eq("rst_err", 32'(err_timeout), 32'd0);
    check_eq("rst_lit", 32'(lit_count()), 32'd0);
    req_game   = 1'b1;
    game_bits  = 256'h1;
    game_color = 24'h040404;
    goto(101);
    check_eq("single_gnt_early", 32'(gnt_game), 32'd0);
    goto(102);
    check_eq("single_gnt", 32'(gnt_game), 32'd1);
    check_eq("single_upd_early", 32'(drv_update), 32'd0);
    req_game = 1'b0;
    goto(103);
    check_eq("single_upd", 32'(drv_update), 32'd1);
    check_eq("single_gnt_drop", 32'(gnt_game), 32'd0);
    check_eq("single_led15", 32'(drv_data[15]), 32'h040404);
    check_eq("single_lit", 32'(lit_count()), 32'd1);
    goto(125);
    check_eq("single_fc_before", 32'(frame_count), 32'd0);
    goto(126);
    check_eq("single_fc_after", 32'(frame_count), 32'd1);

    // serpentine corners
    game_bits     = '0;
    game_bits[16] = 1'b1;
    game_bits[31] = 1'b1;
    game_bits[15] = 1'b1;
    game_color    = 24'h112233;
    req_game      = 1'b1;
    goto(202);
    check_eq("map_gnt", 32'(gnt_game), 32'd1);
    req_game = 1'b0;
    goto(203);
    check_eq("map_led16", 32'(drv_data[16]), 32'h112233);
    check_eq("map_led31", 32'(drv_data[31]), 32'h112233);
    check_eq("map_led0", 32'(drv_data[0]), 32'h112233);
    check_eq("map_led15_clear", 32'(drv_data[15]), 32'h0);
    check_eq("map_lit", 32'(lit_count()), 32'd3);

    // round-robin, then forced debug
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      dbg_force  = (pass == 1);
      req_game   = 1'b1;
      req_dbg    = 1'b1;
      game_bits  = 256'h1;
      game_color = 24'h0000aa;
      dbg_bits   = 256'h2;
      dbg_color  = 24'hbb0000;
      for (int f = 1; f <= 4; f++) begin
        goto(f * FP + 2);
        check_eq($sformatf("arb%0d_f%0d_gnt_dbg", pass, f), 32'(gnt_dbg), 32'(exp_dbg[pass][f-1]));
        check_eq($sformatf("arb%0d_f%0d_gnt_game", pass, f), 32'(gnt_game), 32'(!exp_dbg[pass][f-1]));
        goto(f * FP + 3);
        check_eq($sformatf("arb%0d_f%0d_led14", pass, f), 32'(drv_data[14]),
                 exp_dbg[pass][f-1] ? 32'hbb0000 : 32'h0);
        check_eq($sformatf("arb%0d_f%0d_led15", pass, f), 32'(drv_data[15]),
                 exp_dbg[pass][f-1] ? 32'h0 : 32'h0000aa);
      end
    end

    // long busy: frame counted on the fall, no extra update while busy
    do_reset();
    busy_dly   = 10;
    busy_len   = 500;
    req_game   = 1'b1;
    game_bits  = 256'h1;
    game_color = 24'h010203;
    goto(102);
    req_game = 1'b0;
    goto(613);
    check_eq("long_fc_before", 32'(frame_count), 32'd0);
    check_eq("long_upd_count", 32'(n_upd), 32'd1);
    goto(614);
    check_eq("long_fc_after", 32'(frame_count), 32'd1);
    check_eq("long_err", 32'(err_timeout), 32'd0);
    busy_dly = 2;
    busy_len = 20;

    // driver never goes busy
    drv_en = 1'b0;
    do_reset();
    req_game   = 1'b1;
    game_bits  = 256'h1;
    game_color = 24'h040404;
    goto(102);
    req_game = 1'b0;
    goto(166);
    check_eq("to_err_before", 32'(err_timeout), 32'd0);
    goto(167);
    check_eq("to_err_at", 32'(err_timeout), 32'd1);
    req_game = 1'b1;
    goto(202);
    check_eq("to_next_gnt", 32'(gnt_game), 32'd1);
    req_game = 1'b0;
    goto(203);
    check_eq("to_next_upd", 32'(drv_update), 32'd1);
    check_eq("to_err_sticky", 32'(err_timeout), 32'd1);
    check_eq("to_fc", 32'(frame_count), 32'd0);
    drv_en = 1'b1;

    // async reset during WAIT_DN with five frames done
    do_reset();
    req_game   = 1'b1;
    game_bits  = 256'h1;
    game_color = 24'h040404;
    goto(610);
    check_eq("ar_fc5", 32'(frame_count), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_fc", 32'(frame_count), 32'd0);
    check_eq("ar_upd", 32'(drv_update), 32'd0);
    check_eq("ar_gnt", 32'(gnt_game), 32'd0);
    check_eq("ar_err", 32'(err_timeout), 32'd0);
    check_eq("ar_lit", 32'(lit_count()), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    goto(101);
    check_eq("ar_gnt_early", 32'(gnt_game), 32'd0);
    goto(102);
    check_eq("ar_gnt_first", 32'(gnt_game), 32'd1);
    check_eq("ar_gnt_none_before", 32'(n_gnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
